// File: rtl/cp0_multi_irq_if.sv
// Pipeline-side bus of coprocessor 0: mtc0/mfc0 access, exception commit and fetch redirect.
// The pipeline drives it through the master modport; cp0 sits on the slave modport.
interface cp0_multi_irq_if;
    logic        write_enable;
    logic [4:0]  number;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        has_exception_in_pipeline;
    logic        is_exception;
    logic        is_bd;
    logic [4:0]  exception_cause;
    logic [31:0] exception_pc;
    logic [31:0] exception_badvaddr;
    logic        jump;
    logic [31:0] jump_address;

    modport master (
        output write_enable, number, write_data, has_exception_in_pipeline, is_exception,
               is_bd, exception_cause, exception_pc, exception_badvaddr,
        input  read_data, jump, jump_address
    );

    modport slave (
        input  write_enable, number, write_data, has_exception_in_pipeline, is_exception,
               is_bd, exception_cause, exception_pc, exception_badvaddr,
        output read_data, jump, jump_address
    );
endinterface

// File: rtl/cp0_multi_irq.sv
// Coprocessor 0 with configurable external interrupt lines, compare timers and
// optional vectored interrupt dispatch.
module cp0_multi_irq #(
    parameter int unsigned N_EXT         = 5,
    parameter int unsigned N_TIMER       = 1,
    parameter logic [31:0] HANDLER_BASE  = 32'hBFC00380,
    parameter int unsigned VECTORED      = 0,
    parameter int unsigned VECTOR_STRIDE = 32,
    parameter logic [4:0]  ERET_CODE     = 5'h1F,
    parameter logic [31:0] PRID          = 32'hDEADBEEF
) (
    input  logic             clk,
    input  logic             reset,
    cp0_multi_irq_if.slave   bus,
    input  logic [N_EXT-1:0] external_interrupt,
    output logic             interrupt_now
);

    logic [31:0] countQ, countD;
    logic [31:0] compare0Q, compare0D;
    logic [31:0] compare1Q, compare1D;
    logic [1:0]  pendingQ, pendingD;
    logic [7:2]  ipHwQ, ipHwD;
    logic [1:0]  ipSwQ, ipSwD;
    logic [7:0]  imQ, imD;
    logic        exlQ, exlD;
    logic        ieQ, ieD;
    logic        bdQ, bdD;
    logic [4:0]  excCodeQ, excCodeD;
    logic [31:0] epcQ, epcD;
    logic [31:0] badVAddrQ, badVAddrD;

    logic [5:0]  extPad;
    logic [7:0]  ip;
    logic [7:0]  ipMasked;
    logic        wrOk;
    logic        isEret;
    logic        match0;
    logic        match1;
    logic        vecHit;
    logic [2:0]  vecIdx;
    logic [31:0] vecAddr;

    assign extPad   = 6'(external_interrupt);
    assign ip       = {ipHwQ, ipSwQ};
    assign ipMasked = ip & imQ;
    assign wrOk     = bus.write_enable & ~bus.is_exception;
    assign isEret   = (bus.exception_cause == ERET_CODE);
    assign match0   = (countQ == compare0Q) && (compare0Q != 32'd0);
    assign match1   = (N_TIMER == 2) && (countQ == compare1Q) && (compare1Q != 32'd0);

    assign interrupt_now = ieQ & ~exlQ & ~bus.has_exception_in_pipeline & (|ipMasked);

    // Highest pending-and-enabled line wins; IP7 has top priority.
    always_comb begin
        vecHit = 1'b0;
        vecIdx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (ipMasked[i]) begin
                vecHit = 1'b1;
                vecIdx = 3'(i);
            end
        end
        vecAddr = HANDLER_BASE + 32'(VECTOR_STRIDE) * (32'd7 - 32'(vecIdx));
    end

    always_comb begin
        bus.jump         = bus.is_exception;
        bus.jump_address = 32'd0;
        if (bus.is_exception) begin
            if (isEret) begin
                bus.jump_address = epcQ;
            end else if ((VECTORED == 1) && (bus.exception_cause == 5'd0) && vecHit) begin
                bus.jump_address = vecAddr;
            end else begin
                bus.jump_address = HANDLER_BASE;
            end
        end
    end

    always_comb begin
        case (bus.number)
            5'd8:    bus.read_data = badVAddrQ;
            5'd9:    bus.read_data = countQ;
            5'd10:   bus.read_data = (N_TIMER == 2) ? compare1Q : 32'd0;
            5'd11:   bus.read_data = compare0Q;
            5'd12:   bus.read_data = {16'd0, imQ, 6'd0, exlQ, ieQ};
            5'd13:   bus.read_data = {bdQ, 15'd0, ip, 1'b0, excCodeQ, 2'b00};
            5'd14:   bus.read_data = epcQ;
            5'd15:   bus.read_data = PRID;
            default: bus.read_data = 32'd0;
        endcase
    end

    always_comb begin
        countD    = countQ + 32'd1;
        compare0D = compare0Q;
        compare1D = compare1Q;
        ipSwD     = ipSwQ;
        imD       = imQ;
        exlD      = exlQ;
        ieD       = ieQ;
        bdD       = bdQ;
        excCodeD  = excCodeQ;
        epcD      = epcQ;
        badVAddrD = badVAddrQ;

        // Hardware IP bits track their sources every cycle, exceptions included.
        ipHwD = extPad;
        ipHwD[7] = ipHwD[7] | pendingQ[0];
        if (N_TIMER == 2) begin
            ipHwD[6] = ipHwD[6] | pendingQ[1];
        end

        pendingD[0] = pendingQ[0] | match0;
        pendingD[1] = pendingQ[1] | match1;

        if (wrOk) begin
            case (bus.number)
                5'd9:  countD = bus.write_data;
                5'd10: begin
                    if (N_TIMER == 2) begin
                        compare1D   = bus.write_data;
                        pendingD[1] = 1'b0;
                    end
                end
                5'd11: begin
                    compare0D   = bus.write_data;
                    pendingD[0] = 1'b0;
                end
                5'd12: begin
                    imD  = bus.write_data[15:8];
                    exlD = bus.write_data[1];
                    ieD  = bus.write_data[0];
                end
                5'd13: ipSwD = bus.write_data[9:8];
                default: ;
            endcase
        end

        if (bus.is_exception) begin
            if (isEret) begin
                exlD = 1'b0;
            end else if (!exlQ) begin
                badVAddrD = bus.exception_badvaddr;
                bdD       = bus.is_bd;
                excCodeD  = bus.exception_cause;
                exlD      = 1'b1;
                epcD      = bus.is_bd ? (bus.exception_pc - 32'd4) : bus.exception_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            countQ    <= 32'd0;
            compare0Q <= 32'd0;
            compare1Q <= 32'd0;
            pendingQ  <= 2'b00;
            ipHwQ     <= 6'd0;
            ipSwQ     <= 2'b00;
            imQ       <= 8'hFF;
            exlQ      <= 1'b1;
            ieQ       <= 1'b0;
            bdQ       <= 1'b0;
            excCodeQ  <= 5'd0;
            epcQ      <= 32'd0;
            badVAddrQ <= 32'd0;
        end else begin
            countQ    <= countD;
            compare0Q <= compare0D;
            compare1Q <= compare1D;
            pendingQ  <= pendingD;
            ipHwQ     <= ipHwD;
            ipSwQ     <= ipSwD;
            imQ       <= imD;
            exlQ      <= exlD;
            ieQ       <= ieD;
            bdQ       <= bdD;
            excCodeQ  <= excCodeD;
            epcQ      <= epcD;
            badVAddrQ <= badVAddrD;
        end
    end

endmodule

// File: tb/tb_cp0_multi_irq.sv
// Directed bench for cp0_multi_irq: default instance plus a vectored two-timer instance.
module tb_cp0_multi_irq;

    logic clk;
    logic reset;
    logic vreset;
    logic [4:0] ext;
    logic [1:0] vext;
    logic irq;
    logic vIrq;
    int   errors;
    int   checks;

    cp0_multi_irq_if bus ();
    cp0_multi_irq_if vbus ();

    cp0_multi_irq dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus),
        .external_interrupt(ext),
        .interrupt_now     (irq)
    );

    cp0_multi_irq #(
        .N_EXT   (2),
        .N_TIMER (2),
        .VECTORED(1)
    ) dutV (
        .clk               (clk),
        .reset             (vreset),
        .bus               (vbus),
        .external_interrupt(vext),
        .interrupt_now     (vIrq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] num, input logic [31:0] data);
        bus.write_enable = 1'b1;
        bus.number       = num;
        bus.write_data   = data;
        step();
        bus.write_enable = 1'b0;
    endtask

    task automatic vmtc0(input logic [4:0] num, input logic [31:0] data);
        vbus.write_enable = 1'b1;
        vbus.number       = num;
        vbus.write_data   = data;
        step();
        vbus.write_enable = 1'b0;
    endtask

    task automatic checkReg(input string tag, input logic [4:0] num, input logic [31:0] exp);
        bus.number = num;
        #1;
        check(tag, bus.read_data, exp);
    endtask

    task automatic vcheckReg(input string tag, input logic [4:0] num, input logic [31:0] exp);
        vbus.number = num;
        #1;
        check(tag, vbus.read_data, exp);
    endtask

    task automatic clearBus();
        bus.write_enable = 1'b0;
        bus.number = 5'd0;
        bus.write_data = 32'd0;
        bus.has_exception_in_pipeline = 1'b0;
        bus.is_exception = 1'b0;
        bus.is_bd = 1'b0;
        bus.exception_cause = 5'd0;
        bus.exception_pc = 32'd0;
        bus.exception_badvaddr = 32'd0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        vreset = 1'b1;
        ext    = '0;
        vext   = '0;
        clearBus();
        vbus.write_enable = 1'b0;
        vbus.number = 5'd0;
        vbus.write_data = 32'd0;
        vbus.has_exception_in_pipeline = 1'b0;
        vbus.is_exception = 1'b0;
        vbus.is_bd = 1'b0;
        vbus.exception_cause = 5'd0;
        vbus.exception_pc = 32'd0;
        vbus.exception_badvaddr = 32'd0;
        step();
        step();
        reset  = 1'b0;
        vreset = 1'b0;

        // Reset state
        checkReg("reset_sr", 5'd12, 32'h0000FF02);
        checkReg("reset_prid", 5'd15, 32'hDEADBEEF);
        checkReg("reset_cause", 5'd13, 32'h0);
        checkReg("reset_epc", 5'd14, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_jump", {31'd0, bus.jump}, 32'd0);
        check("reset_jaddr", bus.jump_address, 32'd0);

        // Timer 0: Count=1 after the Compare write, match at Count==10
        mtc0(5'd12, 32'h0000FF01);
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd10);
        repeat (10) step();
        check("timer_irq_early", {31'd0, irq}, 32'd0);
        step();
        check("timer_irq_rise", {31'd0, irq}, 32'd1);
        checkReg("timer_cause_ip7", 5'd13, 32'h00008000);
        mtc0(5'd11, 32'd0);
        check("timer_irq_hold", {31'd0, irq}, 32'd1);
        step();
        check("timer_irq_clear", {31'd0, irq}, 32'd0);

        // Exception in a delay slot, with a concurrent SR write that must be dropped
        bus.is_exception = 1'b1;
        bus.exception_cause = 5'd4;
        bus.is_bd = 1'b1;
        bus.exception_pc = 32'h00400010;
        bus.exception_badvaddr = 32'h12345678;
        bus.write_enable = 1'b1;
        bus.number = 5'd12;
        bus.write_data = 32'h0;
        #1;
        check("exc_jump", {31'd0, bus.jump}, 32'd1);
        check("exc_target", bus.jump_address, 32'hBFC00380);
        step();
        clearBus();
        checkReg("exc_epc", 5'd14, 32'h0040000C);
        checkReg("exc_cause", 5'd13, 32'h80000010);
        checkReg("exc_sr_drop", 5'd12, 32'h0000FF03);
        checkReg("exc_badvaddr", 5'd8, 32'h12345678);

        // Nested exception: redirect only
        bus.is_exception = 1'b1;
        bus.exception_cause = 5'd5;
        bus.exception_pc = 32'h00500000;
        bus.exception_badvaddr = 32'hAAAA0000;
        #1;
        check("nest_target", bus.jump_address, 32'hBFC00380);
        step();
        clearBus();
        checkReg("nest_epc", 5'd14, 32'h0040000C);
        checkReg("nest_badvaddr", 5'd8, 32'h12345678);

        // ERET clears EXL
        bus.is_exception = 1'b1;
        bus.exception_cause = 5'h1F;
        #1;
        check("eret_jump", {31'd0, bus.jump}, 32'd1);
        check("eret_target", bus.jump_address, 32'h0040000C);
        step();
        clearBus();
        checkReg("eret_sr", 5'd12, 32'h0000FF01);

        // ERET with EXL=0 changes nothing
        bus.is_exception = 1'b1;
        bus.exception_cause = 5'h1F;
        step();
        clearBus();
        checkReg("eret2_sr", 5'd12, 32'h0000FF01);
        checkReg("eret2_cause", 5'd13, 32'h80000010);

        // Count load, increment and wrap
        mtc0(5'd9, 32'd100);
        checkReg("count_load", 5'd9, 32'd100);
        step();
        checkReg("count_inc", 5'd9, 32'd101);
        mtc0(5'd9, 32'hFFFFFFFF);
        checkReg("count_max", 5'd9, 32'hFFFFFFFF);
        step();
        checkReg("count_wrap", 5'd9, 32'h0);

        // Software IP bits and pipeline suppression
        mtc0(5'd13, 32'hFFFFFFFF);
        checkReg("cause_sw_ip", 5'd13, 32'h80000310);
        check("sw_irq", {31'd0, irq}, 32'd1);
        bus.has_exception_in_pipeline = 1'b1;
        #1;
        check("sw_irq_suppress", {31'd0, irq}, 32'd0);
        bus.has_exception_in_pipeline = 1'b0;
        mtc0(5'd13, 32'h0);
        checkReg("cause_sw_clear", 5'd13, 32'h80000010);
        check("sw_irq_clear", {31'd0, irq}, 32'd0);

        // External line 2 -> IP4 after one edge
        ext = 5'b00100;
        #1;
        check("ext_irq_before", {31'd0, irq}, 32'd0);
        step();
        check("ext_irq", {31'd0, irq}, 32'd1);
        checkReg("ext_cause", 5'd13, 32'h80001010);
        ext = '0;
        step();

        // Compare1 absent, unmapped and read-only registers ignore writes
        mtc0(5'd10, 32'd55);
        checkReg("cmp1_absent", 5'd10, 32'd0);
        mtc0(5'd3, 32'h5A5A5A5A);
        checkReg("unmapped", 5'd3, 32'd0);
        mtc0(5'd15, 32'h1);
        checkReg("prid_ro", 5'd15, 32'hDEADBEEF);

        // Reset discards a concurrent exception
        bus.is_exception = 1'b1;
        bus.exception_cause = 5'd4;
        bus.exception_pc = 32'h00001000;
        reset = 1'b1;
        step();
        reset = 1'b0;
        clearBus();
        checkReg("rst_exc_epc", 5'd14, 32'h0);
        checkReg("rst_exc_sr", 5'd12, 32'h0000FF02);
        checkReg("rst_exc_cause", 5'd13, 32'h0);

        // Vectored instance
        vmtc0(5'd12, 32'h0000FF01);
        vmtc0(5'd10, 32'd55);
        vcheckReg("v_cmp1", 5'd10, 32'd55);
        vbus.is_exception = 1'b1;
        vbus.exception_cause = 5'd0;
        #1;
        check("v_none_target", vbus.jump_address, 32'hBFC00380);
        vbus.is_exception = 1'b0;
        vext = 2'b10;
        step();
        check("v_irq", {31'd0, vIrq}, 32'd1);
        vbus.is_exception = 1'b1;
        vbus.exception_cause = 5'd0;
        #1;
        // ext[1] sits on IP3: HANDLER_BASE + 32*(7-3)
        check("v_vec_target", vbus.jump_address, 32'hBFC00400);
        vbus.exception_cause = 5'd4;
        #1;
        check("v_nonint_target", vbus.jump_address, 32'hBFC00380);
        vbus.is_exception = 1'b0;
        vext = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
